// File: rtl/gbt_rx_frameclk_pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gbt_rx_frameclk_pkg
// Shared definitions for the RX frame-clock PLL reset sequencer:
//   - pll_state_t : FSM state encoding, also exported on the status port
//   - DEF_*       : default parameter values for the controller
//   - max3()      : helper used to size the shared timer
// -----------------------------------------------------------------------------
package gbt_rx_frameclk_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_READY     = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_t;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRIES   = 4;
   localparam int unsigned DEF_CNT_W         = 8;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/gbt_rx_frameclk_pll_ctrl_if.sv
// -----------------------------------------------------------------------------
// gbt_rx_frameclk_pll_ctrl_if
// Bundles the PLL-facing and status/control signals of the frame-clock PLL
// controller.
//   pll_locked     : PLL locked indication (asynchronous to refclk)
//   reset_req      : single-cycle request to re-run the bring-up sequence
//   clear_cnt      : clears the lock-loss counter
//   pll_rst        : PLL reset, active high
//   frameclk_ready : PLL locked and qualified
//   fail           : retry budget exhausted
//   state          : current sequencer state (status)
//   lock_loss_cnt  : saturating count of lock losses seen while ready
// modport master : the controller side; modport slave : PLL/status side.
// -----------------------------------------------------------------------------
interface gbt_rx_frameclk_pll_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             pll_locked;
   logic             reset_req;
   logic             clear_cnt;
   logic             pll_rst;
   logic             frameclk_ready;
   logic             fail;
   logic [2:0]       state;
   logic [CNT_W-1:0] lock_loss_cnt;

   modport master (
      input  pll_locked, reset_req, clear_cnt,
      output pll_rst, frameclk_ready, fail, state, lock_loss_cnt
   );

   modport slave (
      output pll_locked, reset_req, clear_cnt,
      input  pll_rst, frameclk_ready, fail, state, lock_loss_cnt
   );
endinterface

// File: rtl/gbt_rx_frameclk_pll_ctrl_sync.sv
// -----------------------------------------------------------------------------
// gbt_bit_sync_2ff
// Generic two-flop single-bit synchroniser with synchronous active-low reset.
//   clk   : destination clock
//   rst_n : synchronous reset, active low (clears both stages)
//   d     : asynchronous input bit
//   q     : synchronised output, two clk cycles of latency
// -----------------------------------------------------------------------------
module gbt_bit_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;
endmodule

// File: rtl/gbt_rx_frameclk_pll_ctrl.sv
// -----------------------------------------------------------------------------
// gbt_rx_frameclk_pll_ctrl
// Reset sequencer and lock monitor for the RX frame-clock PLL. Holds the PLL
// in reset, waits for lock with a timeout/retry budget, qualifies lock over a
// run of consecutive locked cycles, and watches for lock loss while ready.
//   refclk : 120 MHz RX reference clock (only clock of the block)
//   rst_n  : synchronous reset, active low
//   bus    : master side of gbt_rx_frameclk_pll_ctrl_if (PLL + status/control)
// All outputs are registered.
// -----------------------------------------------------------------------------
module gbt_rx_frameclk_pll_ctrl
   import gbt_rx_frameclk_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic                          refclk,
   input  logic                          rst_n,
   gbt_rx_frameclk_pll_ctrl_if.master    bus
);

   // One timer is shared by every state; size it for the longest interval.
   localparam int unsigned TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int          TIMER_W   = $clog2(TIMER_MAX) + 1;
   localparam int          RETRY_W   = $clog2(MAX_RETRIES) + 1;

   localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

   pll_state_t         state_reg;
   logic [TIMER_W-1:0] timer_reg;
   logic [RETRY_W-1:0] retry_reg;
   logic [CNT_W-1:0]   lock_loss_cnt_reg;
   logic               pll_rst_reg;
   logic               ready_reg;
   logic               fail_reg;

   logic               locked_s;
   logic               lock_loss;

   gbt_bit_sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (bus.pll_locked),
      .q     (locked_s)
   );

   // A loss is counted even if a reset_req forces the state change that cycle.
   assign lock_loss = (state_reg == ST_READY) && !locked_s;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_reg         <= ST_RESET_PLL;
         timer_reg         <= '0;
         retry_reg         <= '0;
         lock_loss_cnt_reg <= '0;
         pll_rst_reg       <= 1'b1;
         ready_reg         <= 1'b0;
         fail_reg          <= 1'b0;
      end else begin
         // Lock-loss counter: clear dominates, increment saturates.
         if (bus.clear_cnt) begin
            lock_loss_cnt_reg <= '0;
         end else if (lock_loss && (lock_loss_cnt_reg != '1)) begin
            lock_loss_cnt_reg <= lock_loss_cnt_reg + CNT_W'(1);
         end

         if (bus.reset_req) begin
            state_reg   <= ST_RESET_PLL;
            timer_reg   <= '0;
            retry_reg   <= '0;
            pll_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
         end else begin
            case (state_reg)
               ST_RESET_PLL: begin
                  if (timer_reg == RST_LAST) begin
                     state_reg   <= ST_WAIT_LOCK;
                     timer_reg   <= '0;
                     pll_rst_reg <= 1'b0;
                  end else begin
                     timer_reg <= timer_reg + TIMER_W'(1);
                  end
               end

               ST_WAIT_LOCK: begin
                  if (locked_s) begin
                     state_reg <= ST_STABILIZE;
                     timer_reg <= '0;
                  end else if (timer_reg == TIMEOUT_LAST) begin
                     timer_reg   <= '0;
                     retry_reg   <= retry_reg + RETRY_W'(1);
                     pll_rst_reg <= 1'b1;
                     // Last permitted retry just expired: give up.
                     if (retry_reg == RETRY_LAST) begin
                        state_reg <= ST_FAIL;
                        fail_reg  <= 1'b1;
                     end else begin
                        state_reg <= ST_RESET_PLL;
                     end
                  end else begin
                     timer_reg <= timer_reg + TIMER_W'(1);
                  end
               end

               ST_STABILIZE: begin
                  if (!locked_s) begin
                     // Glitch: restart the timeout window, keep retry budget.
                     state_reg <= ST_WAIT_LOCK;
                     timer_reg <= '0;
                  end else if (timer_reg == STABLE_LAST) begin
                     state_reg <= ST_READY;
                     timer_reg <= '0;
                     retry_reg <= '0;
                     ready_reg <= 1'b1;
                  end else begin
                     timer_reg <= timer_reg + TIMER_W'(1);
                  end
               end

               ST_READY: begin
                  if (!locked_s) begin
                     state_reg   <= ST_RESET_PLL;
                     timer_reg   <= '0;
                     ready_reg   <= 1'b0;
                     pll_rst_reg <= 1'b1;
                  end
               end

               ST_FAIL: begin
                  // Sticky until reset_req or rst_n.
                  pll_rst_reg <= 1'b1;
                  fail_reg    <= 1'b1;
               end

               default: begin
                  state_reg   <= ST_RESET_PLL;
                  timer_reg   <= '0;
                  retry_reg   <= '0;
                  pll_rst_reg <= 1'b1;
                  ready_reg   <= 1'b0;
                  fail_reg    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.pll_rst        = pll_rst_reg;
   assign bus.frameclk_ready = ready_reg;
   assign bus.fail           = fail_reg;
   assign bus.state          = state_reg;
   assign bus.lock_loss_cnt  = lock_loss_cnt_reg;

endmodule

// File: doc/gbt_rx_frameclk_pll_ctrl.md
# gbt_rx_frameclk_pll_ctrl

Reset sequencer and lock monitor for the RX frame-clock standard PLL (120 MHz recovered word clock in, 40 MHz frame clock out). Drives the PLL's active-high reset, synchronises and qualifies its asynchronous `locked` output, and produces a single qualified `frameclk_ready` flag that gates release of the RX frame-domain logic. Retries the PLL on lock timeout, declares failure after a bounded number of retries, and counts lock losses for the status registers.

## Interface
- `RST_CYCLES`, 16: cycles the PLL reset is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before ready (≥1).
- `MAX_RETRIES`, 4: timeouts tolerated before FAIL (≥1).
- `CNT_W`, 8: lock-loss counter width.

- `refclk` in 1: 120 MHz RX reference clock, the same clock that feeds the PLL; the block's only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `reset_req` in 1: single-cycle software request to re-run the sequence.
- `clear_cnt` in 1: clears `lock_loss_cnt`.
- `pll_rst` out 1: to the PLL `rst`, active high.
- `frameclk_ready` out 1: PLL locked and qualified.
- `fail` out 1: retry budget exhausted.
- `state` out 3: current FSM state encoding, for status.
- `lock_loss_cnt` out `CNT_W`: lock losses seen while READY, saturating.

## Operation
- `pll_locked` passes through a 2-FF synchroniser; the FSM sees `locked_s` only.
- States: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, READY=3, FAIL=4.
- RESET_PLL: `pll_rst`=1; the timer counts `RST_CYCLES` cycles, then → WAIT_LOCK with the timer cleared.
- WAIT_LOCK: `pll_rst`=0.
  - `locked_s`=1 → STABILIZE.
  - Timer reaches `LOCK_TIMEOUT`-1 without lock → retry_cnt+1. If the new value equals `MAX_RETRIES`, → FAIL; otherwise → RESET_PLL.
- STABILIZE: counts consecutive `locked_s`=1 cycles.
  - `locked_s`=0 → WAIT_LOCK with the timeout timer restarted. Retry_cnt is unchanged.
  - Count reaches `STABLE_CYCLES` → READY, and retry_cnt clears.
- READY: `frameclk_ready`=1. `locked_s`=0 → `lock_loss_cnt`+1 (saturating at all-ones) and → RESET_PLL.
- FAIL: `fail`=1 and `pll_rst`=1. The block leaves FAIL only via `reset_req` or `rst_n`.
- `reset_req` in any state → RESET_PLL, clearing the timer and retry_cnt. It takes precedence over every other transition.
  - If it coincides with a READY lock loss, the loss is still counted.
- `clear_cnt` zeroes `lock_loss_cnt`; clear wins over a same-cycle increment.
- One shared timer serves all states and is wide enough for max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`).

## Timing
- All outputs are registered.
- Reset values:
  - `pll_rst`=1, `frameclk_ready`=0, `fail`=0.
  - `state`=RESET_PLL, `lock_loss_cnt`=0.
  - Timer, retry_cnt and synchroniser=0.
- Reset sequence: cycle 0 is the first edge with `rst_n`=1. `pll_rst` is high for cycles 0..`RST_CYCLES`-1 and low from cycle `RST_CYCLES`.
- `pll_locked` rise → `locked_s` 2 cycles later → STABILIZE 1 cycle after that.
- `frameclk_ready` rises `STABLE_CYCLES` cycles after entering STABILIZE.
- `pll_locked` fall in READY → `frameclk_ready`=0 and `pll_rst`=1 exactly 3 cycles later (2 synchroniser + 1 FSM).
- `rst_n` low mid-sequence forces all reset values on the next edge.

## Structure
- Package `gbt_rx_frameclk_pkg`: the state enum with its encodings, and default parameter constants.
- Sub-module `gbt_bit_sync_2ff`: the generic 2-flop synchroniser with a synchronous active-low reset, reused elsewhere in the RX path.
- FSM, timer and counters stay in the top module.

## Test plan
Parameters for all scenarios: `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Nominal bring-up: release reset, raise `pll_locked` at cycle 10 → `pll_rst` high for cycles 0–3; `frameclk_ready` rises at cycle 21; `lock_loss_cnt`=0.
- Glitch in STABILIZE: drop `pll_locked` for 1 cycle after 5 locked cycles → `state` returns to WAIT_LOCK; `frameclk_ready` rises 8 cycles after re-entering STABILIZE.
- Lock loss in READY: drop `pll_locked` → 3 cycles later `frameclk_ready`=0, `pll_rst`=1, `lock_loss_cnt`=1. Repeat 300 times with `CNT_W`=8 → counter holds at 255.
- Timeout to FAIL: keep `pll_locked`=0 → two 32-cycle WAIT_LOCK windows, then `fail`=1, `pll_rst`=1, `state`=4. A `reset_req` pulse → `fail`=0 and `state`=0 next cycle.
- Simultaneous events: `clear_cnt` with a READY lock loss → `lock_loss_cnt`=0. `reset_req` with a READY lock loss → count increments and `state`=RESET_PLL.
- Mid-sequence reset: assert `rst_n`=0 during STABILIZE → next edge shows all reset values.
